if_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage that generalises the single-PC fetch unit. It generates the PC with a fixed redirect priority and issues one-request-per-cycle reads to instruction memory. Fetched words are buffered in a DEPTH-entry queue with a valid/ready handshake to decode. Interrupt entry is precise: it saves the oldest undelivered PC, and interrupts arriving while masked stay pending.

---
 rtl/if_fetch_queue_if.sv | 30 +++
 rtl/if_fetch_queue.sv | 173 +++++++++++++++++
 tb/tb_if_fetch_queue.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory request/response and the
// valid/ready instruction handshake towards decode.
interface if_fetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic [XLEN-1:0] mem_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus_4;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rdata,
    output out_valid, out_instr, out_pc, out_pc_plus_4,
    input  out_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rdata,
    input  out_valid, out_instr, out_pc, out_pc_plus_4,
    output out_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: prioritised PC redirect, one outstanding memory
// read, DEPTH-entry instruction queue to decode and precise interrupt entry.
module if_fetch_queue #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] INT_VECTOR = XLEN'(32'h100)
) (
  input  logic                clk,
  input  logic                rst,
  if_fetch_queue_if.master    bus,
  input  logic                alert,
  input  logic                int_return,
  input  logic                branch_undo,
  input  logic                pcr_take,
  input  logic                pci_take,
  input  logic                branch_predict,
  input  logic [XLEN-1:0]     pc_not_taken,
  input  logic [XLEN-1:0]     pcr,
  input  logic [XLEN-1:0]     branch_pc,
  output logic                interrupt,
  output logic                interrupt_mask,
  output logic [XLEN-1:0]     epc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             discard_q, discard_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic             pending_q, pending_d;
  logic             mask_q, mask_d;
  logic             interrupt_q, interrupt_d;
  logic [XLEN-1:0]  epc_q, epc_d;

  logic [XLEN-1:0]  instr_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_q    [DEPTH];

  logic             branch_redirect;
  logic [XLEN-1:0]  branch_target;
  logic             int_take;
  logic             flush;
  logic [OCC_W-1:0] occupancy;
  logic             mem_req_c;
  logic             accept;
  logic             out_valid_c;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  oldest_pc;

  // Redirect priority decode; an interrupt only wins when no branch redirects.
  always_comb begin
    branch_redirect = branch_undo | pcr_take | pci_take | branch_predict;
    branch_target   = branch_pc;
    if (branch_undo) begin
      branch_target = pc_not_taken;
    end else if (pcr_take) begin
      branch_target = pcr;
    end
    int_take = (alert | pending_q) & ~mask_q & ~branch_redirect;
    flush    = branch_redirect | int_take;
  end

  // Request credit counts the outstanding read; pops this cycle give no credit.
  always_comb begin
    occupancy   = OCC_W'(count_q) + OCC_W'(inflight_q);
    mem_req_c   = ~rst & (occupancy < OCC_W'(DEPTH));
    accept      = mem_req_c & bus.mem_gnt;
    out_valid_c = (count_q != '0) & ~flush;
    pop         = out_valid_c & bus.out_ready;
    push        = inflight_q & ~discard_q & ~flush;
  end

  // Oldest PC not yet handed to decode: queue head, then live in-flight read, then fetch PC.
  always_comb begin
    oldest_pc = pc_q;
    if (count_q != '0) begin
      oldest_pc = pc_mem_q[rd_ptr_q];
    end else if (inflight_q && !discard_q) begin
      oldest_pc = inflight_pc_q;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = accept;
    discard_d     = accept & flush;
    inflight_pc_d = inflight_pc_q;
    pending_d     = ~int_take & (pending_q | alert);
    mask_d        = int_take | (mask_q & ~int_return);
    interrupt_d   = int_take;
    epc_d         = epc_q;

    if (accept) begin
      inflight_pc_d = pc_q;
    end
    if (int_take) begin
      epc_d = oldest_pc;
    end

    // A flush empties the queue and orphans any read issued this cycle.
    if (flush) begin
      pc_d     = int_take ? INT_VECTOR : branch_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        pc_d = pc_q + XLEN'(4);
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      discard_q     <= 1'b0;
      inflight_pc_q <= '0;
      pending_q     <= 1'b0;
      mask_q        <= 1'b0;
      interrupt_q   <= 1'b0;
      epc_q         <= '0;
    end else begin
      pc_q          <= pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      discard_q     <= discard_d;
      inflight_pc_q <= inflight_pc_d;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      interrupt_q   <= interrupt_d;
      epc_q         <= epc_d;
    end
  end

  // Queue storage needs no reset; entries are only read when count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.mem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign bus.mem_req       = mem_req_c;
  assign bus.mem_addr      = pc_q;
  assign bus.out_valid     = out_valid_c;
  assign bus.out_instr     = instr_mem_q[rd_ptr_q];
  assign bus.out_pc        = pc_mem_q[rd_ptr_q];
  assign bus.out_pc_plus_4 = pc_mem_q[rd_ptr_q] + XLEN'(4);

  assign interrupt      = interrupt_q;
  assign interrupt_mask = mask_q;
  assign epc            = epc_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a stream-level model predicts fetches,
// deliveries and interrupt entries; a negedge monitor compares against the DUT.
module tb_if_fetch_queue;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned DEPTH      = 4;
  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam logic [31:0] INT_VECTOR = 32'h100;
  localparam logic [31:0] RD_KEY     = 32'hA5A5_0000;

  typedef struct {
    int          cyc;
    bit          rst;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    bit          irq;
    bit          mask;
    logic [31:0] epc;
  } cyc_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] epc;
  } int_exp_t;

  typedef struct {
    logic [31:0] pc;
    int          acc;
  } fetch_t;

  logic        clk;
  logic        rst;
  logic        alert, int_return;
  logic        branch_undo, pcr_take, pci_take, branch_predict;
  logic [31:0] pc_not_taken, pcr, branch_pc;
  logic        interrupt, interrupt_mask;
  logic [31:0] epc;

  if_fetch_queue_if #(.XLEN(XLEN)) bus ();

  if_fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .INT_VECTOR(INT_VECTOR)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alert(alert), .int_return(int_return),
    .branch_undo(branch_undo), .pcr_take(pcr_take), .pci_take(pci_take),
    .branch_predict(branch_predict),
    .pc_not_taken(pc_not_taken), .pcr(pcr), .branch_pc(branch_pc),
    .interrupt(interrupt), .interrupt_mask(interrupt_mask), .epc(epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cyc_exp_t    cq[$];
  int_exp_t    int_q[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  int          irqs = 0;

  // Stream-level model state
  fetch_t      fq[$];
  logic [31:0] m_pc, m_epc;
  bit          m_pend, m_mask;
  int          ghost_cyc, take_cyc, cyc;
  bit          rsp_pend;
  logic [31:0] rsp_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_pc      = RESET_PC;
    m_epc     = 32'h0;
    m_pend    = 1'b0;
    m_mask    = 1'b0;
    ghost_cyc = -10;
    take_cyc  = -10;
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, advance model.
  task automatic step(input bit r, input bit al, input bit iret,
                      input bit bu, input bit pr, input bit pi, input bit bp,
                      input bit gnt, input bit rdy,
                      input logic [31:0] t_nt, input logic [31:0] t_r, input logic [31:0] t_b);
    cyc_exp_t    e;
    int_exp_t    ie;
    fetch_t      f;
    bit          br, take, vld, req, acc;
    logic [31:0] tgt;
    int          occ;
    @(posedge clk);
    #1;
    cyc++;
    bus.mem_rdata  = rsp_pend ? (rsp_addr ^ RD_KEY) : $urandom;
    rst            = r;
    alert          = al;
    int_return     = iret;
    branch_undo    = bu;
    pcr_take       = pr;
    pci_take       = pi;
    branch_predict = bp;
    pc_not_taken   = t_nt;
    pcr            = t_r;
    branch_pc      = t_b;
    bus.mem_gnt    = gnt;
    bus.out_ready  = rdy;

    br   = bu | pr | pi | bp;
    tgt  = bu ? t_nt : (pr ? t_r : t_b);
    take = !r && (al || m_pend) && !m_mask && !br;
    occ  = fq.size() + ((ghost_cyc == cyc - 1) ? 1 : 0);
    req  = !r && (occ < DEPTH);
    vld  = !r && !br && !take && (fq.size() > 0) && (fq[0].acc <= cyc - 2);

    e.cyc = cyc; e.rst = r; e.req = req; e.addr = m_pc; e.valid = vld;
    e.irq = (take_cyc == cyc - 1); e.mask = m_mask; e.epc = m_epc;
    cq.push_back(e);

    if (r) begin
      model_reset();
    end else begin
      if (vld && rdy) begin
        exp_q.push_back(fq[0].pc);
        void'(fq.pop_front());
      end
      acc = req && gnt;
      if (take) begin
        ie.cyc   = cyc;
        ie.epc   = (fq.size() > 0) ? fq[0].pc : m_pc;
        m_epc    = ie.epc;
        take_cyc = cyc;
        int_q.push_back(ie);
      end
      if (br || take) begin
        fq.delete();
        if (acc) ghost_cyc = cyc;
        m_pc = take ? INT_VECTOR : tgt;
      end else if (acc) begin
        f.pc  = m_pc;
        f.acc = cyc;
        fq.push_back(f);
        m_pc = m_pc + 32'd4;
      end
      m_pend = !take && (m_pend || al);
      m_mask = take ? 1'b1 : (iret ? 1'b0 : m_mask);
    end
    #1;
    rsp_pend = bus.mem_req && bus.mem_gnt;
    rsp_addr = bus.mem_addr;
  endtask

  task automatic run(input int n, input bit gnt, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, gnt, rdy, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_tgt();
    if ($urandom_range(0, 5) == 0) return 32'hFFFF_FFF8;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  // Monitor: per-cycle expectations plus delivery and interrupt scoreboards.
  initial begin
    cyc_exp_t    e;
    int_exp_t    ie;
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (cq.size() == 0) continue;
      e = cq.pop_front();
      if (e.rst) begin
        chk("mem_req_in_reset", 32'(bus.mem_req), 32'(0));
        while (int_q.size() > 0 && int_q[0].cyc < e.cyc) void'(int_q.pop_front());
      end else begin
        chk("mem_req", 32'(bus.mem_req), 32'(e.req));
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("out_valid", 32'(bus.out_valid), 32'(e.valid));
        chk("interrupt", 32'(interrupt), 32'(e.irq));
        chk("interrupt_mask", 32'(interrupt_mask), 32'(e.mask));
        chk("epc", epc, e.epc);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          chk("delivery_expected", 32'(exp_q.size() > 0), 32'(1));
          if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            chk("out_pc", bus.out_pc, p);
            chk("out_instr", bus.out_instr, p ^ RD_KEY);
            chk("out_pc_plus_4", bus.out_pc_plus_4, p + 32'd4);
            delivered++;
          end
        end
        if (interrupt === 1'b1) begin
          chk("interrupt_expected", 32'(int_q.size() > 0), 32'(1));
          if (int_q.size() > 0) begin
            ie = int_q.pop_front();
            chk("interrupt_cycle", 32'(e.cyc), 32'(ie.cyc + 1));
            chk("interrupt_epc", epc, ie.epc);
            irqs++;
          end
        end
      end
    end
  end

  initial begin
    bit r, al, iret, bu, pr, pi, bp, gnt, rdy;
    rst = 1'b1; alert = 1'b0; int_return = 1'b0;
    branch_undo = 1'b0; pcr_take = 1'b0; pci_take = 1'b0; branch_predict = 1'b0;
    pc_not_taken = '0; pcr = '0; branch_pc = '0;
    bus.mem_gnt = 1'b0; bus.out_ready = 1'b0; bus.mem_rdata = '0;
    cyc = 0; rsp_pend = 1'b0; rsp_addr = '0;
    model_reset();

    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(12, 1, 1);                                        // streaming
    run(8, 1, 0);                                         // back-pressure fills queue
    run(6, 1, 1);
    step(0, 0, 0, 1, 1, 1, 0, 1, 1, 32'd20, 32'd30, 32'd10);
    run(6, 1, 1);
    run(3, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);             // interrupt with queued head
    run(3, 1, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);             // masked -> pending
    run(3, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);             // return releases pending
    run(4, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 32'd40, 0);
    step(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 32'd10);        // alert blocked by branch
    run(6, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    run(6, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);             // reset with full queue
    run(4, 1, 1);

    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 399) == 0);
      al   = ($urandom_range(0, 19) == 0);
      iret = ($urandom_range(0, 19) == 0);
      bu   = ($urandom_range(0, 39) == 0);
      pr   = ($urandom_range(0, 39) == 0);
      pi   = ($urandom_range(0, 39) == 0);
      bp   = ($urandom_range(0, 39) == 0);
      gnt  = ($urandom_range(0, 9) < 8);
      rdy  = ($urandom_range(0, 9) < 7);
      step(r, al, iret, bu, pr, pi, bp, gnt, rdy, rand_tgt(), rand_tgt(), rand_tgt());
    end
    run(6, 1, 1);

    repeat (2) @(negedge clk);
    #1;
    chk("leftover_deliveries", 32'(exp_q.size()), 32'(0));
    chk("leftover_interrupts", 32'(int_q.size()), 32'(0));
    chk("enough_deliveries", 32'(delivered >= 300), 32'(1));
    chk("enough_interrupts", 32'(irqs >= 3), 32'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
